// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Optional macro ALU_ARBITER_STATS_EN adds per-requester saturating grant counters.
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req0_in0,
  input  logic [DATA_W-1:0] req0_in1,
  input  logic [DATA_W-1:0] req1_in0,
  input  logic [DATA_W-1:0] req1_in1,
  input  logic [1:0]        req0_op,
  input  logic [1:0]        req1_op,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
`ifdef ALU_ARBITER_STATS_EN
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1,
`endif
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] cap_in0;
  logic [DATA_W-1:0] cap_in1;
  logic [1:0]        cap_op;
  logic              cap_id;
  logic              last_grant;

  logic              grant_slot;
  logic              grant_ok;
  logic              pick;
  logic [DATA_W-1:0] sel_in0;
  logic [DATA_W-1:0] sel_in1;
  logic [1:0]        sel_op;

  // A grant slot exists in IDLE, or in RESP when the current response is consumed.
  // Gating with rst_n keeps both readys low while reset is held.
  always_comb begin
    grant_slot = (state == IDLE) || ((state == RESP) && rsp_ready);
    grant_ok   = rst_n && grant_slot && (req0_valid || req1_valid);
    pick       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = grant_ok && !pick;
    req1_ready = grant_ok && pick;
    sel_in0    = pick ? req1_in0 : req0_in0;
    sel_in1    = pick ? req1_in1 : req0_in1;
    sel_op     = pick ? req1_op  : req0_op;
  end

  assign alu_in0 = cap_in0;
  assign alu_in1 = cap_in1;
  assign alu_op  = cap_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cap_in0    <= '0;
      cap_in1    <= '0;
      cap_op     <= 2'b00;
      cap_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            cap_in0    <= sel_in0;
            cap_in1    <= sel_in1;
            cap_op     <= sel_op;
            cap_id     <= pick;
            last_grant <= pick;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (grant_ok) begin
              cap_in0    <= sel_in0;
              cap_in1    <= sel_in1;
              cap_op     <= sel_op;
              cap_id     <= pick;
              last_grant <= pick;
              state      <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else begin
      if (req0_ready && (grant_cnt0 != 8'hFF)) grant_cnt0 <= grant_cnt0 + 8'h01;
      if (req1_ready && (grant_cnt1 != 8'hFF)) grant_cnt1 <= grant_cnt1 + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single-op vector table plus arbitration,
// backpressure, round-robin and reset-abort sequences.
module tb_alu_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_in0 = '0, req0_in1 = '0, req1_in0 = '0, req1_in1 = '0;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] alu_in0, alu_in1, alu_out;
  logic [1:0]   alu_op;
  logic         rsp_valid, rsp_id;
  logic [W-1:0] rsp_data;
  logic         rsp_ready = 1'b0;
`ifdef ALU_ARBITER_STATS_EN
  logic [7:0]   grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_in0(req0_in0), .req0_in1(req0_in1),
    .req1_in0(req1_in0), .req1_in1(req1_in1),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
`ifdef ALU_ARBITER_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .rsp_ready(rsp_ready)
  );

  // External ALU reference
  logic signed [W-1:0] sra_src;
  always_comb begin
    sra_src = alu_in0;
    case (alu_op)
      2'b00:   alu_out = alu_in0 & alu_in1;
      2'b01:   alu_out = alu_in0 + alu_in1;
      2'b10:   alu_out = alu_in0 - alu_in1;
      default: alu_out = sra_src >>> alu_in1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [1:0]   op;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   grants[$];
  int   first_rsp_t, second_rsp_t;

  initial begin
    vecs[0] = '{1'b0, 8'h02, 8'h02, 2'b00, 8'h02};
    vecs[1] = '{1'b1, 8'h7F, 8'h01, 2'b01, 8'h80};
    vecs[2] = '{1'b0, 8'h00, 8'h01, 2'b10, 8'hFF};
    vecs[3] = '{1'b1, 8'h80, 8'h07, 2'b11, 8'hFF};
    vecs[4] = '{1'b0, 8'h7F, 8'h03, 2'b11, 8'h0F};
    vecs[5] = '{1'b1, 8'hF0, 8'h3C, 2'b00, 8'h30};

    // Reset state, with requests already pending
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_alu_in0", alu_in0, 0);
    chk("rst_alu_op", alu_op, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    do_reset();

    // Single-requester table, response held one cycle before consumption
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].id) begin
        req1_valid = 1'b1; req1_in0 = vecs[i].in0; req1_in1 = vecs[i].in1; req1_op = vecs[i].op;
      end else begin
        req0_valid = 1'b1; req0_in0 = vecs[i].in0; req0_in1 = vecs[i].in1; req0_op = vecs[i].op;
      end
      #1;
      chk($sformatf("v%0d_ready0", i), req0_ready, !vecs[i].id);
      chk($sformatf("v%0d_ready1", i), req1_ready, vecs[i].id);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_exec_op", i), alu_op, vecs[i].op);
      chk($sformatf("v%0d_exec_in0", i), alu_in0, vecs[i].in0);
      chk($sformatf("v%0d_exec_valid", i), rsp_valid, 0);
      step();
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp);
      chk($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].id);
      step();
      chk($sformatf("v%0d_rsp_hold", i), rsp_data, vecs[i].exp);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_drop", i), rsp_valid, 0);
    end

    // Simultaneous requests after reset: req0 wins, req1 follows back-to-back
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_in0 = 8'hF0; req0_in1 = 8'hAA; req0_op = 2'b01;
    req1_valid = 1'b1; req1_in0 = 8'hF0; req1_in1 = 8'hAA; req1_op = 2'b10;
    #1;
    chk("tie_ready0", req0_ready, 1);
    chk("tie_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("tie_exec_ready1", req1_ready, 0);
    step();
    first_rsp_t = $time;
    chk("tie_rsp0_valid", rsp_valid, 1);
    chk("tie_rsp0_data", rsp_data, 8'h9A);
    chk("tie_rsp0_id", rsp_id, 0);
    chk("tie_resp_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    chk("tie_gap_valid", rsp_valid, 0);
    step();
    second_rsp_t = $time;
    chk("tie_rsp1_valid", rsp_valid, 1);
    chk("tie_rsp1_data", rsp_data, 8'h46);
    chk("tie_rsp1_id", rsp_id, 1);
    chk("tie_spacing", second_rsp_t - first_rsp_t, 20);
    step();
    chk("tie_idle_valid", rsp_valid, 0);

    // Backpressure: SRAI response held for 5 cycles with a competing request
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_in0 = 8'h80; req1_in1 = 8'h01; req1_op = 2'b11;
    #1;
    chk("bp_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    step();
    req0_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_valid", c), rsp_valid, 1);
      chk($sformatf("bp%0d_data", c), rsp_data, 8'hC0);
      chk($sformatf("bp%0d_id", c), rsp_id, 1);
      chk($sformatf("bp%0d_ready0", c), req0_ready, 0);
      chk($sformatf("bp%0d_ready1", c), req1_ready, 0);
      step();
    end
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 0);

    // Continuous contention: six grants alternate starting with requester 0
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_in0 = 8'h01; req0_in1 = 8'h01; req0_op = 2'b01;
    req1_valid = 1'b1; req1_in0 = 8'h03; req1_in1 = 8'h01; req1_op = 2'b10;
    for (int c = 0; c < 30 && grants.size() < 6; c++) begin
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (grants.size() < 6) step();
    end
    chk("rr_grant_count", grants.size(), 6);
    for (int g = 0; g < grants.size() && g < 6; g++)
      chk($sformatf("rr_grant%0d", g), grants[g], g % 2);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
`ifdef ALU_ARBITER_STATS_EN
    chk("stats_cnt0", grant_cnt0, 3);
    chk("stats_cnt1", grant_cnt1, 3);
`endif
    chk("rr_drain_valid", rsp_valid, 0);

    // Reset during EXEC discards the in-flight operation
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_in0 = 8'h1F; req0_in1 = 8'h04; req0_op = 2'b11;
    #1;
    chk("abort_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("abort_exec_in0", alu_in0, 8'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_valid", rsp_valid, 0);
    chk("abort_rst_in0", alu_in0, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("abort_no_rsp%0d", c), rsp_valid, 0);
      step();
    end
    chk("abort_rsp_data", rsp_data, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("abort_tie_ready0", req0_ready, 1);
    chk("abort_tie_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
